// File: rtl/id_ex_stage_register_bank.sv
// ID/EX pipeline register bank: DEPTH stages carrying the decoded bundle,
// with async reset, stall, flush, valid tracking and a bubble counter.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   stall, flush                 hold all stages / squash all (flush wins)
//   in_valid, in_ctrl, in_rs_data, in_rt_data, in_imm,
//   in_dest_reg, in_write_destination_reg      bundle from ID
//   out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm,
//   out_dest_reg, out_write_destination_reg    bundle of last stage
//   bubble_count                 saturating count of bubbles created
module id_ex_stage_register_bank #(
  parameter int CTRL_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 1,
  parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic [DATA_WIDTH-1:0]     in_rs_data,
  input  logic [DATA_WIDTH-1:0]     in_rt_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest_reg,
  input  logic                      in_write_destination_reg,
  output logic                      out_valid,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic [DATA_WIDTH-1:0]     out_rs_data,
  output logic [DATA_WIDTH-1:0]     out_rt_data,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic [REG_ADDR_WIDTH-1:0] out_dest_reg,
  output logic                      out_write_destination_reg,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("id_ex_stage_register_bank: DEPTH must be 1..4");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                      valid_q [DEPTH];
  logic [CTRL_WIDTH-1:0]     ctrl_q  [DEPTH];
  logic [DATA_WIDTH-1:0]     rs_q    [DEPTH];
  logic [DATA_WIDTH-1:0]     rt_q    [DEPTH];
  logic [DATA_WIDTH-1:0]     imm_q   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] dest_q  [DEPTH];
  logic                      write_q [DEPTH];

  // Select rather than AND so X on in_ctrl cannot leak into a bubble.
  logic [CTRL_WIDTH-1:0] s0_ctrl;
  logic                  s0_write;
  logic                  bubble_now;

  always_comb begin
    s0_ctrl    = in_valid ? in_ctrl : BUBBLE_CTRL;
    s0_write   = in_write_destination_reg & in_valid;
    bubble_now = flush | (~stall & ~in_valid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= BUBBLE_CTRL;
        write_q[k] <= 1'b0;
        rs_q[k]    <= '0;
        rt_q[k]    <= '0;
        imm_q[k]   <= '0;
        dest_q[k]  <= '0;
      end
    end else if (flush) begin
      // Data and dest fields keep their values; only control is squashed.
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ctrl_q[k]  <= BUBBLE_CTRL;
        write_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      ctrl_q[0]  <= s0_ctrl;
      write_q[0] <= s0_write;
      rs_q[0]    <= in_rs_data;
      rt_q[0]    <= in_rt_data;
      imm_q[0]   <= in_imm;
      dest_q[0]  <= in_dest_reg;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ctrl_q[k]  <= ctrl_q[k-1];
        write_q[k] <= write_q[k-1];
        rs_q[k]    <= rs_q[k-1];
        rt_q[k]    <= rt_q[k-1];
        imm_q[k]   <= imm_q[k-1];
        dest_q[k]  <= dest_q[k-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bubble_now && bubble_count != CNT_MAX) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  assign out_valid                 = valid_q[DEPTH-1];
  assign out_ctrl                  = ctrl_q[DEPTH-1];
  assign out_rs_data               = rs_q[DEPTH-1];
  assign out_rt_data               = rt_q[DEPTH-1];
  assign out_imm                   = imm_q[DEPTH-1];
  assign out_dest_reg              = dest_q[DEPTH-1];
  assign out_write_destination_reg = write_q[DEPTH-1];

endmodule

// File: tb/tb_id_ex_stage_register_bank.sv
// Bench for id_ex_stage_register_bank (DEPTH=3, CNT_WIDTH=4).
// Random and directed stimulus against a queue-style reference model.
module tb_id_ex_stage_register_bank;

  localparam int D = 3;
  localparam int CW = 4;
  localparam logic [7:0] BUB = 8'hA5;
  localparam int CMAX = 15;

  logic clock = 0;
  logic reset, stall, flush, in_valid, in_wr;
  logic [7:0] in_ctrl;
  logic [31:0] in_rs, in_rt, in_imm;
  logic [4:0] in_dest;
  logic out_valid, out_wr;
  logic [7:0] out_ctrl;
  logic [31:0] out_rs, out_rt, out_imm;
  logic [4:0] out_dest;
  logic [CW-1:0] bubble_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic v;
    logic [7:0] c;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0] d;
    logic w;
  } st_t;

  st_t m [D];
  int cnt;

  id_ex_stage_register_bank #(
    .CTRL_WIDTH(8), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5),
    .DEPTH(D), .BUBBLE_CTRL(BUB), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_rs_data(in_rs), .in_rt_data(in_rt), .in_imm(in_imm),
    .in_dest_reg(in_dest), .in_write_destination_reg(in_wr),
    .out_valid(out_valid), .out_ctrl(out_ctrl),
    .out_rs_data(out_rs), .out_rt_data(out_rt), .out_imm(out_imm),
    .out_dest_reg(out_dest), .out_write_destination_reg(out_wr),
    .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  wire [114:0] obs = {out_valid, out_ctrl, out_rs, out_rt, out_imm,
                      out_dest, out_wr, bubble_count};

  function automatic logic [114:0] expv();
    logic [CW-1:0] c4;
    c4 = CW'(cnt);
    return {m[D-1], c4};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < D; k++) begin
      m[k] = '0;
      m[k].c = BUB;
    end
    cnt = 0;
  endfunction

  function automatic void bump();
    if (cnt < CMAX) cnt++;
  endfunction

  // One rising edge as seen by the pipeline contents.
  function automatic void model_edge();
    st_t n;
    if (reset) return;
    if (flush) begin
      for (int k = 0; k < D; k++) begin
        m[k].v = 0;
        m[k].c = BUB;
        m[k].w = 0;
      end
      bump();
    end else if (!stall) begin
      for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
      n.v = in_valid;
      n.c = in_valid ? in_ctrl : BUB;
      n.rs = in_rs;
      n.rt = in_rt;
      n.imm = in_imm;
      n.d = in_dest;
      n.w = in_valid && in_wr;
      m[0] = n;
      if (!in_valid) bump();
    end
  endfunction

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0; in_wr = 0;
    in_ctrl = 0; in_rs = 0; in_rt = 0; in_imm = 0; in_dest = 0;
  endtask

  task automatic rand_instr();
    in_valid = 1;
    in_wr = 1'($urandom);
    in_ctrl = 8'($urandom);
    in_rs = $urandom;
    in_rt = $urandom;
    in_imm = $urandom;
    in_dest = 5'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clock);
    reset = 1;
    model_reset();
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    model_reset();
    #3;
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_init got %h want %h", obs, expv());
    end
    cyc();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      rand_instr();
      in_wr = 1;
      cyc();
    end
    checks++;
    if (out_valid !== 1'b1 || obs !== expv()) begin
      errors++;
      $display("FAIL reset_prefill got %h want %h", obs, expv());
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (obs !== expv() || out_ctrl !== BUB) begin
      errors++;
      $display("FAIL reset_async got %h want %h", obs, expv());
    end
    cyc();
    reset = 0;
  endtask

  task automatic test_stream();
    logic [7:0] cs [3];
    logic [4:0] ds [3];
    cs = '{8'h11, 8'h22, 8'h33};
    ds = '{5'd5, 5'd6, 5'd7};
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      if (e <= 3) begin
        rand_instr();
        in_ctrl = cs[e-1];
        in_dest = ds[e-1];
        in_wr = 1;
      end else begin
        idle_inputs();
      end
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL stream_e%0d got %h want %h", e, obs, expv());
      end
      if (e >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== cs[e-3] ||
            out_dest !== ds[e-3] || out_wr !== 1'b1) begin
          errors++;
          $display("FAIL stream_out_e%0d got v=%b c=%h d=%0d want c=%h d=%0d",
                   e, out_valid, out_ctrl, out_dest, cs[e-3], ds[e-3]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [114:0] frozen;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      in_ctrl = (i == 2) ? 8'h22 : 8'h10 + 8'(i);
      cyc();
    end
    frozen = obs;
    rand_instr();
    in_ctrl = 8'h99;
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (obs !== frozen || obs !== expv()) begin
        errors++;
        $display("FAIL stall_hold%0d got %h want %h", i, obs, frozen);
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (obs !== expv() || out_ctrl === 8'h99) begin
        errors++;
        $display("FAIL stall_drop%0d got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_flush();
    logic [4:0] old_dest;
    int old_cnt;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      in_wr = 1;
      cyc();
    end
    old_dest = out_dest;
    old_cnt = cnt;
    rand_instr();
    in_wr = 1;
    stall = 1;
    flush = 1;
    cyc();
    checks++;
    if (out_valid !== 0 || out_wr !== 0 || out_ctrl !== BUB ||
        out_dest !== old_dest || int'(bubble_count) !== old_cnt + 1) begin
      errors++;
      $display("FAIL flush_edge got v=%b w=%b c=%h d=%0d n=%0d want d=%0d n=%0d",
               out_valid, out_wr, out_ctrl, out_dest, bubble_count,
               old_dest, old_cnt + 1);
    end
    stall = 0;
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL flush_drain%0d got %h want %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_gating();
    int old_cnt;
    do_reset();
    old_cnt = cnt;
    rand_instr();
    in_valid = 0;
    in_wr = 1;
    in_dest = 5'd31;
    in_ctrl = 'x;
    cyc();
    idle_inputs();
    in_valid = 1;
    in_ctrl = 8'h01;
    cyc();
    cyc();
    checks++;
    if (out_wr !== 0 || out_valid !== 0 || out_ctrl !== BUB ||
        out_dest !== 5'd31 || int'(bubble_count) !== old_cnt + 1) begin
      errors++;
      $display("FAIL gating got v=%b w=%b c=%h d=%0d n=%0d want n=%0d",
               out_valid, out_wr, out_ctrl, out_dest, bubble_count,
               old_cnt + 1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    idle_inputs();
    for (int i = 1; i <= 20; i++) begin
      if (i % 3 == 0) flush = 1;
      else flush = 0;
      cyc();
      checks++;
      if (int'(bubble_count) !== ((i < CMAX) ? i : CMAX)) begin
        errors++;
        $display("FAIL sat_%0d got %0d want %0d", i, bubble_count,
                 (i < CMAX) ? i : CMAX);
      end
    end
    flush = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (i % 97 == 50) do_reset();
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random_%0d got %h want %h", i, obs, expv());
      end
      checks++;
      if (out_wr === 1'b1 && out_valid !== 1'b1) begin
        errors++;
        $display("FAIL random_inv_%0d got w=1 v=%b want v=1", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_gating();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
